// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte output bundle of the UART receiver
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_busy;

   modport master (output rx_data, rx_valid, rx_frame_err, rx_busy);
   modport slave  (input  rx_data, rx_valid, rx_frame_err, rx_busy);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and one-cycle result strobes
module uart_rx #(
   parameter int CLK_FREQ = 50000000,
   parameter int UART_BPS = 115200
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      RX,
   uart_rx_if.master rx
);
   localparam int          BPS_CNT   = CLK_FREQ / UART_BPS;
   localparam int          HALF_CNT  = BPS_CNT / 2;
   localparam logic [15:0] BPS_LAST  = 16'(BPS_CNT - 1);
   localparam logic [15:0] HALF_LAST = 16'(HALF_CNT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state, state_nxt;
   logic        rx_s1, rx_s2, rx_s3;
   logic        fall;
   logic [15:0] clk_cnt, clk_cnt_nxt;
   logic [3:0]  bit_cnt, bit_cnt_nxt;
   logic [7:0]  shift, shift_nxt;
   logic [7:0]  data_q, data_nxt;
   logic        valid_q, valid_nxt;
   logic        err_q, err_nxt;

   // rx_s3 tracks rx_s2 in every state, so a line held low never re-triggers
   assign fall = rx_s3 & ~rx_s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_s3   <= 1'b1;
         state   <= IDLE;
         clk_cnt <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         rx_s1   <= RX;
         rx_s2   <= rx_s1;
         rx_s3   <= rx_s2;
         state   <= state_nxt;
         clk_cnt <= clk_cnt_nxt;
         bit_cnt <= bit_cnt_nxt;
         shift   <= shift_nxt;
         data_q  <= data_nxt;
         valid_q <= valid_nxt;
         err_q   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clk_cnt_nxt = clk_cnt;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift;
      data_nxt    = data_q;
      valid_nxt   = 1'b0;
      err_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (fall) begin
               state_nxt   = START;
               clk_cnt_nxt = '0;
            end
         end
         START: begin
            if (clk_cnt == HALF_LAST) begin
               clk_cnt_nxt = '0;
               bit_cnt_nxt = '0;
               state_nxt   = rx_s2 ? IDLE : DATA;
            end else begin
               clk_cnt_nxt = clk_cnt + 16'd1;
            end
         end
         DATA: begin
            if (clk_cnt == BPS_LAST) begin
               shift_nxt[bit_cnt[2:0]] = rx_s2;
               clk_cnt_nxt = '0;
               bit_cnt_nxt = bit_cnt + 4'd1;
               if (bit_cnt == 4'd7) state_nxt = STOP;
            end else begin
               clk_cnt_nxt = clk_cnt + 16'd1;
            end
         end
         STOP: begin
            // leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge
            if (clk_cnt == BPS_LAST) begin
               clk_cnt_nxt = '0;
               state_nxt   = IDLE;
               if (rx_s2) begin
                  data_nxt  = shift;
                  valid_nxt = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
            end else begin
               clk_cnt_nxt = clk_cnt + 16'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rx.rx_data      = data_q;
   assign rx.rx_valid     = valid_q;
   assign rx.rx_frame_err = err_q;
   assign rx.rx_busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a line-trace decoding model
module tb_uart_rx;
   localparam int NCYC = 20000;
   localparam int BPS  = 16;
   localparam int HALF = 8;

   typedef struct {
      int         cyc;
      bit         err;
      logic [7:0] data;
   } ev_t;

   logic       clk;
   logic       rst;
   logic       drv_line;
   logic       tx_line;
   logic       loop_en;
   logic       rx_pin;
   int         cyc;
   int         n_checks;
   int         n_errors;
   int         both_cnt;
   logic       line_h [NCYC];
   logic       rst_h  [NCYC];
   ev_t        obs_q[$];
   ev_t        exp_q[$];
   logic [7:0] tx_q[$];

   uart_rx_if rxif ();

   uart_rx #(.CLK_FREQ(1600), .UART_BPS(100)) dut (
      .clk (clk),
      .rst (rst),
      .RX  (rx_pin),
      .rx  (rxif)
   );

   assign rx_pin = loop_en ? tx_line : drv_line;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (cyc < NCYC) begin
         line_h[cyc] = rx_pin;
         rst_h[cyc]  = rst;
      end
   end

   always @(negedge clk) begin
      if (rxif.rx_valid)     obs_q.push_back('{cyc, 1'b0, rxif.rx_data});
      if (rxif.rx_frame_err) obs_q.push_back('{cyc, 1'b1, 8'h00});
      if (rxif.rx_valid && rxif.rx_frame_err) both_cnt++;
   end

   // Loopback transmitter: serialises queued bytes as 8N1 frames, back to back
   initial begin
      logic [7:0] b;
      tx_line = 1'b1;
      forever begin
         if (tx_q.size() == 0) begin
            @(negedge clk);
         end else begin
            b = tx_q.pop_front();
            for (int k = 0; k < 10; k++) begin
               if (k == 0)      tx_line = 1'b0;
               else if (k == 9) tx_line = 1'b1;
               else             tx_line = b[k-1];
               repeat (BPS) @(negedge clk);
            end
            tx_line = 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      drv_line = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_val, input int rst_bit);
      for (int k = 0; k < 10; k++) begin
         if (k == 0)      drv_line = 1'b0;
         else if (k == 9) drv_line = stop_val;
         else             drv_line = b[k-1];
         for (int c = 0; c < BPS; c++) begin
            rst = (k == rst_bit && c == HALF);
            if (k == rst_bit && c == HALF + 1) begin
               check("midframe_rst_data", rxif.rx_data, 8'h00);
               check("midframe_rst_busy", rxif.rx_busy, 1'b0);
            end
            @(negedge clk);
         end
      end
      rst = 1'b0;
   endtask

   // Synchronised line value seen by the receiver during cycle n
   function automatic logic sv(input int n);
      if (n < 2) return 1'b1;
      if (rst_h[n] || rst_h[n-1]) return 1'b1;
      return line_h[n-1];
   endfunction

   function automatic bit fall_at(input int n);
      logic hist;
      hist = rst_h[n] ? 1'b1 : sv(n - 1);
      return hist && !sv(n);
   endfunction

   function automatic int first_rst(input int a, input int b);
      for (int p = a; p <= b; p++) if (rst_h[p]) return p;
      return 0;
   endfunction

   // Decode the recorded line: edge, centre-of-start check, 8 data samples, stop sample
   task automatic run_model();
      int         i, e, p;
      logic [7:0] d;
      i = 2;
      while (i < cyc) begin
         if (!fall_at(i)) begin
            i++;
         end else begin
            e = i;
            if (e + HALF + 9 * BPS + 1 >= cyc) break;
            p = first_rst(e + 1, e + HALF);
            if (p != 0) begin
               i = p;
            end else if (sv(e + HALF)) begin
               i = e + HALF + 1;
            end else begin
               p = first_rst(e + HALF + 1, e + HALF + 9 * BPS + 1);
               if (p != 0) begin
                  i = p;
               end else begin
                  for (int k = 0; k < 8; k++) d[k] = sv(e + HALF + (k + 1) * BPS);
                  if (sv(e + HALF + 9 * BPS)) exp_q.push_back('{e + HALF + 9 * BPS + 1, 1'b0, d});
                  else                       exp_q.push_back('{e + HALF + 9 * BPS + 1, 1'b1, 8'h00});
                  i = e + HALF + 9 * BPS + 1;
               end
            end
         end
      end
   endtask

   initial begin
      int         s, cnt_c7, cnt_err, cnt_val, nmin;
      logic [7:0] b;
      logic       sb;
      n_checks = 0;
      n_errors = 0;
      both_cnt = 0;
      rst      = 1'b1;
      drv_line = 1'b1;
      loop_en  = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      check("reset_data",  rxif.rx_data, 8'h00);
      check("reset_valid", rxif.rx_valid, 1'b0);
      check("reset_err",   rxif.rx_frame_err, 1'b0);
      check("reset_busy",  rxif.rx_busy, 1'b0);
      idle(10);

      s = obs_q.size();
      send_frame(8'h55, 1'b1, -1);
      idle(20);
      check("t1_count", obs_q.size() - s, 1);
      if (obs_q.size() > s) check("t1_kind", obs_q[s].err, 1'b0);
      check("t1_data", rxif.rx_data, 8'h55);
      check("t1_busy", rxif.rx_busy, 1'b0);

      s = obs_q.size();
      send_frame(8'hA3, 1'b1, -1);
      send_frame(8'h0F, 1'b1, -1);
      idle(20);
      check("t2_count", obs_q.size() - s, 2);
      if (obs_q.size() >= s + 2) begin
         check("t2_data0", obs_q[s].data, 8'hA3);
         check("t2_data1", obs_q[s+1].data, 8'h0F);
         check("t2_spacing", obs_q[s+1].cyc - obs_q[s].cyc, 10 * BPS);
      end

      s = obs_q.size();
      drv_line = 1'b0;
      repeat (3) @(negedge clk);
      drv_line = 1'b1;
      repeat (HALF) @(negedge clk);
      check("t3_busy", rxif.rx_busy, 1'b0);
      idle(20);
      check("t3_count", obs_q.size() - s, 0);

      s = obs_q.size();
      send_frame(8'h3C, 1'b0, -1);
      drv_line = 1'b0;
      repeat (100) @(negedge clk);
      check("t4_count", obs_q.size() - s, 1);
      if (obs_q.size() > s) check("t4_kind", obs_q[s].err, 1'b1);
      check("t4_data_held", rxif.rx_data, 8'h0F);
      idle(40);
      check("t4_no_retrigger", obs_q.size() - s, 1);

      s = obs_q.size();
      send_frame(8'hC7, 1'b1, 5);
      idle(300);
      cnt_c7 = 0;
      for (int j = s; j < obs_q.size(); j++) if (!obs_q[j].err && obs_q[j].data == 8'hC7) cnt_c7++;
      check("t5_no_c7", cnt_c7, 0);
      send_frame(8'h81, 1'b1, -1);
      idle(20);
      check("t5_data", rxif.rx_data, 8'h81);
      if (obs_q.size() > s) check("t5_last_kind", obs_q[obs_q.size()-1].err, 1'b0);

      s = obs_q.size();
      loop_en = 1'b1;
      tx_q.push_back(8'h00);
      tx_q.push_back(8'hFF);
      tx_q.push_back(8'h5A);
      repeat (3 * 10 * BPS + 40) @(negedge clk);
      loop_en = 1'b0;
      cnt_err = 0;
      cnt_val = 0;
      for (int j = s; j < obs_q.size(); j++) if (obs_q[j].err) cnt_err++; else cnt_val++;
      check("t6_errors", cnt_err, 0);
      check("t6_count", cnt_val, 3);
      if (obs_q.size() >= s + 3) begin
         check("t6_data0", obs_q[s].data, 8'h00);
         check("t6_data1", obs_q[s+1].data, 8'hFF);
         check("t6_data2", obs_q[s+2].data, 8'h5A);
      end
      idle(20);

      for (int r = 0; r < 24; r++) begin
         b  = 8'($urandom_range(0, 255));
         sb = ($urandom_range(0, 7) != 0);
         send_frame(b, sb, -1);
         idle(sb ? BPS * $urandom_range(0, 2) : BPS + $urandom_range(0, 20));
      end
      idle(300);

      run_model();
      check("model_count", obs_q.size(), exp_q.size());
      nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int j = 0; j < nmin; j++) begin
         check($sformatf("ev%0d_cycle", j), obs_q[j].cyc, exp_q[j].cyc);
         check($sformatf("ev%0d_kind", j), obs_q[j].err, exp_q[j].err);
         if (!exp_q[j].err) check($sformatf("ev%0d_data", j), obs_q[j].data, exp_q[j].data);
      end
      check("valid_and_err_together", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
